mem_bus_bridge: RTL and testbench

// Sequences every M-stage load/store onto the data path: zero-wait accesses go to
// the data memory, handshaked accesses go to peripherals (timer0, timer1, UART).

---
 rtl/mem_bus_bridge.sv | 101 ++++++++++
 tb/tb_mem_bus_bridge.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_bridge.sv
// mem_bus_bridge: routes M-stage loads/stores to zero-wait data memory or handshaked peripherals, with byte enables, stall and error flags
module mem_bus_bridge #(
  parameter logic [31:0] DEV_BASE = 32'h0000_7F00,
  parameter int DEV_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [1:0]  cpu_size,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        cpu_stall,
  output logic        cpu_err,
  output logic        dm_we,
  output logic [3:0]  dm_be,
  output logic [31:0] dm_addr,
  output logic [31:0] dm_wdata,
  input  logic [31:0] dm_rdata,
  output logic        dev_req,
  output logic [1:0]  dev_sel,
  output logic        dev_we,
  output logic [1:0]  dev_addr,
  output logic [31:0] dev_wdata,
  input  logic [31:0] dev_rdata,
  input  logic        dev_ack
);
  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;
  localparam logic [7:0] TO_LAST = 8'(DEV_TIMEOUT - 1);
  state_t state;
  logic [31:0] off, rbuf;
  logic [7:0] cnt;
  logic [3:0] be_raw;
  logic terr, act, mis, is_dev, is_dm, dev_ok, dm_ok, bad, idle;
  assign off = cpu_addr - DEV_BASE;
  assign is_dev = off < 32'h30;
  assign is_dm = cpu_addr < 32'h3000;
  assign act = cpu_req & |cpu_size;
  assign mis = (cpu_size == 2'b01 & |cpu_addr[1:0]) | (cpu_size == 2'b10 & cpu_addr[0]);
  assign dev_ok = act & is_dev & cpu_size == 2'b01 & !mis;
  assign dm_ok = act & is_dm & !mis;
  assign bad = act & !dev_ok & !dm_ok;
  assign idle = state == IDLE;
  always_comb begin
    be_raw = cpu_size == 2'b01 ? 4'b1111 :
             cpu_size == 2'b10 ? (cpu_addr[1] ? 4'b1100 : 4'b0011) :
             4'b0001 << cpu_addr[1:0];
    dm_wdata = cpu_size == 2'b01 ? cpu_wdata :
               cpu_size == 2'b10 ? {2{cpu_wdata[15:0]}} : {4{cpu_wdata[7:0]}};
  end
  assign dm_addr = {cpu_addr[31:2], 2'b00};
  assign dm_be = idle & dm_ok ? be_raw : 4'b0000;
  assign dm_we = idle & dm_ok & cpu_we;
  assign cpu_rdata = state == DONE ? rbuf : idle & dm_ok ? dm_rdata : 32'h0;
  assign cpu_stall = state == WAIT | (idle & dev_ok);
  assign cpu_err = state == DONE ? terr : idle & bad;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      dev_req <= 1'b0;
      dev_sel <= 2'b00;
      dev_we <= 1'b0;
      dev_addr <= 2'b00;
      dev_wdata <= 32'h0;
      rbuf <= 32'h0;
      cnt <= 8'h0;
      terr <= 1'b0;
    end else begin
      case (state)
        IDLE: if (dev_ok) begin
          state <= WAIT;
          dev_req <= 1'b1;
          dev_sel <= off[5:4];
          dev_we <= cpu_we;
          dev_addr <= cpu_addr[3:2];
          dev_wdata <= cpu_wdata;
          cnt <= 8'h0;
        end
        WAIT: begin
          cnt <= cnt + 8'h1;
          if (dev_ack) begin
            rbuf <= dev_rdata;
            dev_req <= 1'b0;
            state <= DONE;
          end else if (cnt == TO_LAST) begin
            rbuf <= 32'h0;
            terr <= 1'b1;
            dev_req <= 1'b0;
            state <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
          terr <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_bus_bridge.sv
// tb_mem_bus_bridge: scoreboard bench for mem_bus_bridge with a delayed-ack peripheral model
module tb_mem_bus_bridge;
  typedef struct {
    logic [31:0] rd;
    logic err;
    logic we;
    logic [3:0] be;
    logic [31:0] wd;
    logic chk_dm;
    int stall;
  } exp_t;
  logic clk = 1'b0, reset = 1'b1;
  logic cpu_req = 1'b0, cpu_we = 1'b0;
  logic [1:0] cpu_size = 2'b00;
  logic [31:0] cpu_addr = 32'h0, cpu_wdata = 32'h0;
  logic [31:0] cpu_rdata, dm_addr, dm_wdata, dm_rdata, dev_wdata;
  logic [31:0] dev_rd = 32'h0;
  logic cpu_stall, cpu_err, dm_we, dev_req, dev_we, dev_ack;
  logic ack_m = 1'b0, stray = 1'b0, ack_en = 1'b0;
  logic [3:0] dm_be;
  logic [1:0] dev_sel, dev_addr;
  logic [1:0] cap_sel, cap_addr;
  logic cap_we;
  logic [31:0] cap_wd;
  int ack_dly = 0, n_acc = 0, req_cyc = 0, dcnt = 0;
  int total = 0, bad = 0;
  exp_t q[$];
  always #5 clk = ~clk;
  assign dm_rdata = {16'hD000, dm_addr[15:0]};
  assign dev_ack = ack_m | stray;
  mem_bus_bridge dut (
    .clk(clk), .reset(reset), .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_size(cpu_size),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .cpu_err(cpu_err), .dm_we(dm_we), .dm_be(dm_be), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .dev_req(dev_req), .dev_sel(dev_sel), .dev_we(dev_we),
    .dev_addr(dev_addr), .dev_wdata(dev_wdata), .dev_rdata(dev_rd), .dev_ack(dev_ack)
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask
  function automatic exp_t mk(input logic [31:0] rd, input logic err, input logic we,
                              input logic [3:0] be, input logic [31:0] wd, input logic chk_dm,
                              input int stall);
    exp_t e;
    e.rd = rd; e.err = err; e.we = we; e.be = be; e.wd = wd; e.chk_dm = chk_dm; e.stall = stall;
    return e;
  endfunction
  function automatic logic [31:0] pat(input logic [31:0] a);
    return {16'hD000, a[15:0]};
  endfunction
  // peripheral: acks ack_dly cycles after dev_req rises, records what it was asked
  initial forever begin
    @(posedge clk);
    #1;
    if (dev_req) begin
      dcnt++;
      if (dcnt == 1) begin
        n_acc++;
        cap_sel = dev_sel; cap_addr = dev_addr; cap_we = dev_we; cap_wd = dev_wdata;
      end
      req_cyc = dcnt;
      ack_m = ack_en && dcnt == ack_dly + 1;
    end else begin
      dcnt = 0;
      ack_m = 1'b0;
    end
  end
  // monitor: every retiring access is compared against the oldest expectation
  initial begin
    int scnt = 0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (!cpu_req || reset) scnt = 0;
      else if (cpu_stall) scnt++;
      else begin
        if (q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected retire at addr %h", cpu_addr);
        end else begin
          e = q.pop_front();
          chk("rdata", cpu_rdata, e.rd);
          chk("err", 32'(cpu_err), 32'(e.err));
          chk("dm_we", 32'(dm_we), 32'(e.we));
          chk("stall_cycles", scnt, e.stall);
          if (e.chk_dm) begin
            chk("dm_be", 32'(dm_be), 32'(e.be));
            chk("dm_wdata", dm_wdata, e.wd);
            chk("dm_addr", dm_addr, {cpu_addr[31:2], 2'b00});
          end
        end
        scnt = 0;
      end
    end
  end
  task automatic issue(input logic we, input logic [1:0] size, input logic [31:0] addr,
                       input logic [31:0] wd, input exp_t e);
    int n = 0;
    q.push_back(e);
    cpu_req = 1'b1; cpu_we = we; cpu_size = size; cpu_addr = addr; cpu_wdata = wd;
    forever begin
      @(negedge clk);
      if (!cpu_stall) break;
      if (++n > 100) begin
        total++; bad++;
        $display("FAIL stall timeout at addr %h", addr);
        break;
      end
    end
    @(posedge clk);
    #1;
    cpu_req = 1'b0;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
  initial begin
    int a0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst dev_req", 32'(dev_req), 0);
    chk("rst dev_sel", 32'(dev_sel), 0);
    chk("rst dev_we", 32'(dev_we), 0);
    chk("rst dev_addr", 32'(dev_addr), 0);
    chk("rst dev_wdata", dev_wdata, 0);
    chk("rst stall", 32'(cpu_stall), 0);
    chk("rst err", 32'(cpu_err), 0);
    chk("rst dm_we", 32'(dm_we), 0);
    chk("rst dm_be", 32'(dm_be), 0);
    chk("rst rdata", cpu_rdata, 0);
    reset = 1'b0;
    @(posedge clk);
    #1;
    issue(1, 2'b11, 32'h13, 32'hAB, mk(pat(32'h10), 0, 1, 4'b1000, 32'hABABABAB, 1, 0));
    issue(1, 2'b10, 32'h2002, 32'h1234BEEF, mk(pat(32'h2000), 0, 1, 4'b1100, 32'hBEEFBEEF, 1, 0));
    issue(1, 2'b01, 32'h100, 32'h11223344, mk(pat(32'h100), 0, 1, 4'b1111, 32'h11223344, 1, 0));
    issue(0, 2'b11, 32'h21, 32'h55, mk(pat(32'h20), 0, 0, 4'b0010, 32'h55555555, 1, 0));
    issue(0, 2'b10, 32'h44, 32'h9876, mk(pat(32'h44), 0, 0, 4'b0011, 32'h98769876, 1, 0));
    issue(1, 2'b00, 32'h40, 32'h1, mk(32'h0, 0, 0, 4'b0000, 32'h0, 0, 0));
    a0 = n_acc; ack_en = 1'b1; ack_dly = 3; dev_rd = 32'h1234;
    issue(0, 2'b01, 32'h7F24, 32'h0, mk(32'h1234, 0, 0, 4'b0000, 32'h0, 0, 5));
    chk("lw dev count", n_acc - a0, 1);
    chk("lw dev_sel", 32'(cap_sel), 2);
    chk("lw dev_addr", 32'(cap_addr), 1);
    chk("lw dev_we", 32'(cap_we), 0);
    chk("lw req cycles", req_cyc, 4);
    a0 = n_acc;
    issue(1, 2'b10, 32'h5, 32'h77, mk(32'h0, 1, 0, 4'b0000, 32'h0, 0, 0));
    issue(1, 2'b11, 32'h7F00, 32'h77, mk(32'h0, 1, 0, 4'b0000, 32'h0, 0, 0));
    issue(0, 2'b01, 32'h4000, 32'h0, mk(32'h0, 1, 0, 4'b0000, 32'h0, 0, 0));
    issue(0, 2'b01, 32'h7F30, 32'h0, mk(32'h0, 1, 0, 4'b0000, 32'h0, 0, 0));
    chk("err no dev access", n_acc - a0, 0);
    ack_en = 1'b0;
    issue(1, 2'b01, 32'h7F10, 32'hDEADBEEF, mk(32'h0, 1, 0, 4'b0000, 32'h0, 0, 16));
    chk("to req cycles", req_cyc, 15);
    chk("to dev_sel", 32'(cap_sel), 1);
    chk("to dev_we", 32'(cap_we), 1);
    chk("to dev_wdata", cap_wd, 32'hDEADBEEF);
    ack_en = 1'b1; ack_dly = 0; dev_rd = 32'hA5A5_0001;
    issue(0, 2'b01, 32'h7F04, 32'h0, mk(32'hA5A5_0001, 0, 0, 4'b0000, 32'h0, 0, 2));
    chk("fast dev_addr", 32'(cap_addr), 1);
    chk("fast dev_sel", 32'(cap_sel), 0);
    a0 = n_acc; ack_dly = 1; dev_rd = 32'h77;
    issue(0, 2'b01, 32'h7F28, 32'h0, mk(32'h77, 0, 0, 4'b0000, 32'h0, 0, 3));
    issue(0, 2'b01, 32'h40, 32'h0, mk(pat(32'h40), 0, 0, 4'b1111, 32'h0, 1, 0));
    chk("b2b dev count", n_acc - a0, 1);
    chk("b2b dev_addr", 32'(cap_addr), 2);
    ack_en = 1'b0;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_size = 2'b01; cpu_addr = 32'h7F08;
    repeat (2) @(posedge clk);
    #1;
    chk("wait dev_req", 32'(dev_req), 1);
    #2;
    reset = 1'b1; cpu_req = 1'b0;
    #1;
    chk("mid rst dev_req", 32'(dev_req), 0);
    chk("mid rst stall", 32'(cpu_stall), 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    stray = 1'b1;
    @(posedge clk);
    #1;
    stray = 1'b0;
    chk("stray dev_req", 32'(dev_req), 0);
    chk("stray stall", 32'(cpu_stall), 0);
    chk("stray err", 32'(cpu_err), 0);
    chk("stray rdata", cpu_rdata, 0);
    issue(1, 2'b01, 32'h2FFC, 32'h0F0F, mk(pat(32'h2FFC), 0, 1, 4'b1111, 32'h0F0F, 1, 0));
    chk("queue drained", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
